// File: rtl/rv32i_types.sv
// Shared RV32I datapath types and the memory responder state encoding.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

endpackage

// File: rtl/mem_array.sv
// Byte-writable word storage: asynchronous read port, synchronous masked write port.
module mem_array
    import rv32i_types::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] widx,
    input  rv32i_word        wdata,
    input  logic [IDX_W-1:0] ridx,
    output rv32i_word        rdata
);

    rv32i_word mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: captures one read/write request, answers with a
// one-cycle mem_resp LATENCY cycles after acceptance, flags read+write collisions.
module mem_responder
    import rv32i_types::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  rv32i_word   mem_wdata,
    output rv32i_word   mem_rdata,
    output logic        mem_resp,
    output logic        err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    mem_resp_state_t  state;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] cap_idx;
    rv32i_word        cap_wdata;
    logic [3:0]       cap_be;
    logic             cap_write;

    logic             accept;
    logic             we;
    logic [IDX_W-1:0] ridx;
    rv32i_word        arr_rdata;

    assign accept = (state == IDLE) && (mem_read ^ mem_write);
    assign we     = (state == RESP) && cap_write && !rst;
    // With LATENCY=1 the read data is registered on the acceptance edge itself,
    // before the captured index exists, so the live address is used in IDLE.
    assign ridx   = (state == IDLE) ? mem_address[IDX_W+1:2] : cap_idx;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .be    (cap_be),
        .widx  (cap_idx),
        .wdata (cap_wdata),
        .ridx  (ridx),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_idx   <= mem_address[IDX_W+1:2];
            cap_wdata <= mem_wdata;
            cap_be    <= mem_byte_enable;
            cap_write <= mem_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_resp  <= 1'b0;
            mem_rdata <= '0;
            err       <= 1'b0;
        end else begin
            mem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read && mem_write) begin
                        err <= 1'b1;
                    end else if (accept) begin
                        cnt <= CNT_LOAD;
                        if (LATENCY > 1) begin
                            state <= BUSY;
                        end else begin
                            state    <= RESP;
                            mem_resp <= 1'b1;
                            if (mem_read) mem_rdata <= arr_rdata;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state    <= RESP;
                        mem_resp <= 1'b1;
                        if (!cap_write) mem_rdata <= arr_rdata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit storage words (power of two, 2..4096).
REQ-002 Parameter LATENCY, default 3, cycles from request acceptance to mem_resp (1..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mem_read  input  1  read request, held high by initiator until mem_resp.
REQ-006 mem_write  input  1  write request, held high by initiator until mem_resp.
REQ-007 mem_byte_enable  input  4  write byte mask, bit i selects byte lane i (bits 8i+7:8i).
REQ-008 mem_address  input  32  byte address; bits 1:0 ignored.
REQ-009 mem_wdata  input  32  write data (rv32i_word).
REQ-010 mem_rdata  output  32  read data (rv32i_word), valid in the mem_resp cycle of a read.
REQ-011 mem_resp  output  1  one-cycle completion pulse for read or write.
REQ-012 err  output  1  sticky protocol-error flag.

Function
REQ-013 FSM states: IDLE, BUSY, RESP; reset state IDLE.
REQ-014 IDLE: on an edge with exactly one of mem_read/mem_write high, capture address, wdata, byte_enable, and op; go to BUSY if LATENCY>1, else RESP.
REQ-015 BUSY: down-counter loaded with LATENCY-2 at acceptance; go to RESP on the edge where the counter is 0, else decrement.
REQ-016 mem_resp is high exactly in RESP, i.e. LATENCY cycles after the acceptance edge; RESP always returns to IDLE on the next edge.
REQ-017 Word index = captured address bits [log2(DEPTH_WORDS)+1:2]; higher address bits are discarded (aliasing/wrap-around, no error).
REQ-018 Read: mem_rdata is driven from the storage word at the captured index and is stable throughout RESP; it holds its last value outside read responses.
REQ-019 Write: the enabled byte lanes of the indexed word are updated on the edge that ends RESP; disabled lanes are unchanged; byte_enable 0000 completes with mem_resp and modifies nothing.
REQ-020 Inputs that change during BUSY/RESP are ignored; only captured values are used.
REQ-021 A request still high in the IDLE cycle after RESP is accepted as a new request.
REQ-022 mem_read and mem_write both high in IDLE: not accepted, no mem_resp, err set to 1; the FSM stays in IDLE.
REQ-023 err is cleared only by rst.

Reset
REQ-024 rst forces IDLE, clears the latency counter, and drives mem_resp=0, mem_rdata=32'h0, err=0 immediately (asynchronously).
REQ-025 rst asserted during BUSY/RESP aborts the access; a pending write is not committed and no mem_resp is produced.
REQ-026 Storage contents are not cleared by rst; contents after power-up are undefined.

Structure
REQ-027 rv32i_word comes from rv32i_types; state enum mem_resp_state_t (IDLE, BUSY, RESP) is added to rv32i_types.
REQ-028 One sub-module, mem_array: DEPTH_WORDS x 32 byte-writable storage with an asynchronous read port and a synchronous write port with 4-bit byte mask; FSM and counter remain in mem_responder.

Verification
REQ-029 LATENCY=3: write 0x0000_0010 data 0xDEADBEEF be=1111 -> mem_resp high exactly 3 cycles after acceptance, for one cycle; a following read of 0x10 returns 0xDEADBEEF.
REQ-030 Over word 0xDEADBEEF at 0x10, write 0x000000AA with be=0001 -> read of 0x10 returns 0xDEADBEAA; write with be=0000 -> read still returns 0xDEADBEAA.
REQ-031 DEPTH_WORDS=256: write 0x12345678 to 0x0000_0400 -> read of 0x0000_0000 returns 0x12345678 (aliasing).
REQ-032 mem_read and mem_write both high for 5 cycles -> no mem_resp, err=1 and stays 1 after the inputs drop; a subsequent legal read completes normally.
REQ-033 rst pulsed in the second BUSY cycle of a write of 0xCAFEF00D to 0x20 -> no mem_resp, outputs return to reset values; a read of 0x20 returns the prior contents.
REQ-034 LATENCY=1: back-to-back reads with mem_read held high -> mem_resp high every second cycle (RESP, IDLE alternate), correct data each time.
